// File: rtl/fifo_pkg.sv
// Shared defaults and operation encoding for the synchronous FWFT FIFO.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 4;

  // Accepted-operation encoding for one clock edge: {push, pop}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Kept separate so an SRAM macro wrapper can replace it later.
module fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Entries clear on reset so an empty FIFO presents zero on the read port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo.sv
// Single-clock synchronous FIFO with first-word-fall-through read.
// Flags decode from the registered occupancy count with no extra latency.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_valid,
  input  logic             r_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             fifo_full,
  output logic             fifo_empty
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  op_e              op;

  // Explicit wrap keeps non-power-of-two depths exact
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = w_valid && !fifo_full;
  assign pop        = r_ready && !fifo_empty;
  assign op         = decode_op(push, pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      unique case (op)
        OP_PUSH: count <= count + CNT_W'(1);
        OP_POP:  count <= count - CNT_W'(1);
        OP_IDLE,
        OP_BOTH: count <= count;
      endcase
    end
  end

  fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(data_out)
  );

endmodule

// File: tb/tb_fifo.sv
// Directed bench for the FWFT FIFO at DEPTH=3 with a queue scoreboard.
module tb_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             w_valid = 1'b0;
  logic             r_ready = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             fifo_full;
  logic             fifo_empty;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] sb[$];

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_valid   (w_valid),
    .r_ready   (r_ready),
    .data_in   (data_in),
    .data_out  (data_out),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_full"}, 32'(fifo_full), 32'(sb.size() == DEPTH));
    check({tag, "_empty"}, 32'(fifo_empty), 32'(sb.size() == 0));
    if (sb.size() != 0) check({tag, "_head"}, data_out, sb[0]);
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy
  task automatic step(input string tag, input logic wv, input logic rr, input logic [31:0] din);
    logic wr_ok;
    logic rd_ok;
    logic [31:0] exp;
    @(negedge clk);
    w_valid = wv;
    r_ready = rr;
    data_in = din;
    wr_ok = wv && (sb.size() < DEPTH);
    rd_ok = rr && (sb.size() != 0);
    #1;
    if (rd_ok) begin
      exp = sb.pop_front();
      check({tag, "_pop"}, data_out, exp);
    end
    if (wr_ok) sb.push_back(din);
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    r_ready = 1'b0;
    check_flags(tag);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_data", data_out, 32'd0);

    // Fill to full, then a dropped write
    step("fill0", 1'b1, 1'b0, 32'd0);
    step("fill1", 1'b1, 1'b0, 32'd1);
    step("fill2", 1'b1, 1'b0, 32'd2);
    check("full_after3", 32'(fifo_full), 32'd1);
    step("drop", 1'b1, 1'b0, 32'd3);

    // Drain in order, then a read while empty
    step("pop0", 1'b0, 1'b1, 32'd0);
    step("pop1", 1'b0, 1'b1, 32'd0);
    step("pop2", 1'b0, 1'b1, 32'd0);
    check("empty_after_drain", 32'(fifo_empty), 32'd1);
    step("pop_empty", 1'b0, 1'b1, 32'd0);

    // Simultaneous read/write at count=1, at full, and at empty
    step("one", 1'b1, 1'b0, 32'h10);
    step("both1", 1'b1, 1'b1, 32'h11);
    check("both1_head", data_out, 32'h11);
    step("f2", 1'b1, 1'b0, 32'h12);
    step("f3", 1'b1, 1'b0, 32'h13);
    step("both_full", 1'b1, 1'b1, 32'h14);
    step("d1", 1'b0, 1'b1, 32'd0);
    step("d2", 1'b0, 1'b1, 32'd0);
    step("both_empty", 1'b1, 1'b1, 32'h15);
    step("d3", 1'b0, 1'b1, 32'd0);

    // Interleaved traffic to exercise pointer wrap
    step("w_a", 1'b1, 1'b0, 32'hA0);
    step("w_b", 1'b1, 1'b0, 32'hA1);
    step("r_a", 1'b0, 1'b1, 32'd0);
    step("w_c", 1'b1, 1'b0, 32'hA2);
    step("b_d", 1'b1, 1'b1, 32'hA3);
    step("r_b", 1'b0, 1'b1, 32'd0);
    step("w_e", 1'b1, 1'b0, 32'hA4);
    step("r_c", 1'b0, 1'b1, 32'd0);
    step("r_d", 1'b0, 1'b1, 32'd0);
    step("r_e", 1'b0, 1'b1, 32'd0);
    for (int i = 0; i < 40; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    // Asynchronous reset with entries held
    while (sb.size() > 0) step("flush", 1'b0, 1'b1, 32'd0);
    step("h1", 1'b1, 1'b0, 32'hB0);
    step("h2", 1'b1, 1'b0, 32'hB1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    check("arst_empty", 32'(fifo_empty), 32'd1);
    check("arst_full", 32'(fifo_full), 32'd0);
    check("arst_data", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step("post0", 1'b1, 1'b0, 32'hC0);
    step("post1", 1'b1, 1'b0, 32'hC1);
    step("post2", 1'b1, 1'b0, 32'hC2);
    step("post3", 1'b1, 1'b0, 32'hC3);
    step("post_r0", 1'b0, 1'b1, 32'd0);
    step("post_r1", 1'b0, 1'b1, 32'd0);
    step("post_r2", 1'b0, 1'b1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
